// File: rtl/eth_pkg.sv
// Shared constants, types and helper functions for the Ethernet/IPv4 receive parser.
//   - header field constants and header word indices of the 32-bit word stream
//   - FSM state enumeration and the 34-bit TCP beat payload
//   - header check and saturating counter helpers
package eth_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SB_W   = DATA_W + 2;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_TCP   = 8'h06;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  // Header word indices (word 0 carries dmac[47:32] and is handled on entry)
  localparam logic [IDX_W-1:0] W_DMAC_LO = 4'd1;
  localparam logic [IDX_W-1:0] W_ETYPE   = 4'd3;
  localparam logic [IDX_W-1:0] W_VER_IHL = 4'd4;
  localparam logic [IDX_W-1:0] W_PROTO   = 4'd6;
  localparam logic [IDX_W-1:0] W_SRC_IP  = 4'd7;
  localparam logic [IDX_W-1:0] W_DST_IP  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP,
    ST_ABORT
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } tcp_beat_t;

  // Check the header field carried by word idx; words without a field pass.
  function automatic logic hdr_word_ok(
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] data,
    input logic [15:0]       dmac_hi,
    input logic [47:0]       local_mac,
    input logic [31:0]       local_ip,
    input logic [31:0]       remote_ip
  );
    logic [47:0] dmac;
    logic        ok;
    dmac = {dmac_hi, data};
    ok   = 1'b1;
    case (idx)
      W_DMAC_LO: ok = (dmac == local_mac) || (dmac == BCAST_MAC);
      W_ETYPE:   ok = (data[15:0] == ETHERTYPE_IPV4);
      W_VER_IHL: ok = (data[31:24] == IP_VER_IHL);
      W_PROTO:   ok = (data[23:16] == IP_PROTO_TCP);
      W_SRC_IP:  ok = (data == remote_ip);
      W_DST_IP:  ok = (data == local_ip);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Add 0..3 to a counter, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] cnt,
    input logic [1:0]       amt
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(amt);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered outputs.
//   in_data_i/in_valid_i/in_ready_o    : upstream handshake (in_ready_o from registers only)
//   out_data_o/out_valid_o/out_ready_i : downstream handshake
module axis_skid_buffer #(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] head_q, head_d, skid_q, skid_d;
  logic         head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;

  // Room for another word whenever the skid slot is empty (fewer than 2 held).
  assign in_ready_o  = ~skid_vld_q;
  assign out_data_o  = head_q;
  assign out_valid_o = head_vld_q;

  // Head refills from the skid slot first, then from the input; a stalled head parks input in skid.
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!head_vld_q || out_ready_i) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        head_vld_d = in_valid_i;
        if (in_valid_i) head_d = in_data_i;
      end
    end else if (in_valid_i && !skid_vld_q) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  // Storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: rtl/eth_rx_parser.sv
// Ethernet/IPv4/TCP receive header parser: checks and strips the 9 header words,
// forwards the TCP segment and counts accepted and dropped frames.
//   mac_rx_*        : 32-bit MAC word stream in (sof/eof framing)
//   tcp_rx_*        : TCP segment stream out (last, err for aborted frames)
//   frame_*_count   : saturating status counters
module eth_rx_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A80001,
  parameter logic [31:0] REMOTE_IP = 32'hC0A80002
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mac_rx_data,
  input  logic              mac_rx_valid,
  input  logic              mac_rx_sof,
  input  logic              mac_rx_eof,
  output logic              mac_rx_ready,
  output logic [DATA_W-1:0] tcp_rx_data,
  output logic              tcp_rx_valid,
  output logic              tcp_rx_last,
  output logic              tcp_rx_err,
  input  logic              tcp_rx_ready,
  output logic [CNT_W-1:0]  frame_ok_count,
  output logic [CNT_W-1:0]  frame_drop_count
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] hdr_idx_q, hdr_idx_d;
  logic [15:0]      dmac_hi_q, dmac_hi_d;
  logic [CNT_W-1:0] ok_cnt_q, drop_cnt_q;
  logic             rdy_en_q;
  logic             beat, hdr_ok, ok_inc;
  logic [1:0]       drop_amt;
  logic             sb_in_valid, sb_in_ready;
  tcp_beat_t        sb_in_beat, sb_out_beat;

  // Input is held off while the error beat is pending or the skid buffer is full; an
  // unterminated frame's sof is refused in PAYLOAD so it can be replayed from IDLE.
  assign mac_rx_ready = rdy_en_q && (state_q != ST_ABORT) &&
                        !(state_q == ST_PAYLOAD && (!sb_in_ready || mac_rx_sof));
  assign beat   = mac_rx_valid && mac_rx_ready;
  assign hdr_ok = hdr_word_ok(hdr_idx_q, mac_rx_data, dmac_hi_q, LOCAL_MAC, LOCAL_IP, REMOTE_IP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (beat && mac_rx_sof && !mac_rx_eof) state_d = ST_HDR;
      ST_HDR: begin
        if (beat) begin
          if (mac_rx_sof)             state_d = mac_rx_eof ? ST_IDLE : ST_HDR;
          else if (mac_rx_eof)        state_d = ST_IDLE;
          else if (!hdr_ok)           state_d = ST_DROP;
          else if (hdr_idx_q == W_DST_IP) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (mac_rx_valid && mac_rx_sof) state_d = ST_ABORT;
        else if (beat && mac_rx_eof)    state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (beat) begin
          if (mac_rx_sof)      state_d = mac_rx_eof ? ST_IDLE : ST_HDR;
          else if (mac_rx_eof) state_d = ST_IDLE;
        end
      end
      ST_ABORT: if (sb_in_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: header tracking, payload/abort push and counter increments
  always_comb begin
    hdr_idx_d   = hdr_idx_q;
    dmac_hi_d   = dmac_hi_q;
    sb_in_valid = 1'b0;
    sb_in_beat  = '0;
    ok_inc      = 1'b0;
    drop_amt    = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (beat && mac_rx_sof) begin
          hdr_idx_d = W_DMAC_LO;
          dmac_hi_d = mac_rx_data[15:0];
          if (mac_rx_eof) drop_amt = 2'd1;
        end
      end
      ST_HDR: begin
        if (beat) begin
          if (mac_rx_sof) begin
            // abandoned frame, plus the new one if it is a single-word runt
            hdr_idx_d = W_DMAC_LO;
            dmac_hi_d = mac_rx_data[15:0];
            drop_amt  = mac_rx_eof ? 2'd2 : 2'd1;
          end else begin
            hdr_idx_d = hdr_idx_q + IDX_W'(1);
            if (mac_rx_eof || !hdr_ok) drop_amt = 2'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (mac_rx_valid && mac_rx_sof) begin
          drop_amt = 2'd1;
        end else if (beat) begin
          sb_in_valid     = 1'b1;
          sb_in_beat.data = mac_rx_data;
          sb_in_beat.last = mac_rx_eof;
          ok_inc          = mac_rx_eof;
        end
      end
      ST_DROP: begin
        // already counted on entry to DROP
        if (beat && mac_rx_sof) begin
          hdr_idx_d = W_DMAC_LO;
          dmac_hi_d = mac_rx_data[15:0];
          if (mac_rx_eof) drop_amt = 2'd1;
        end
      end
      ST_ABORT: begin
        sb_in_valid     = 1'b1;
        sb_in_beat.last = 1'b1;
        sb_in_beat.err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Header tracking, counters and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx_q  <= '0;
      dmac_hi_q  <= '0;
      ok_cnt_q   <= '0;
      drop_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      hdr_idx_q  <= hdr_idx_d;
      dmac_hi_q  <= dmac_hi_d;
      ok_cnt_q   <= sat_add(ok_cnt_q, {1'b0, ok_inc});
      drop_cnt_q <= sat_add(drop_cnt_q, drop_amt);
      rdy_en_q   <= 1'b1;
    end
  end

  axis_skid_buffer #(.W(SB_W)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (sb_in_beat),
    .in_valid_i  (sb_in_valid),
    .in_ready_o  (sb_in_ready),
    .out_data_o  (sb_out_beat),
    .out_valid_o (tcp_rx_valid),
    .out_ready_i (tcp_rx_ready)
  );

  assign tcp_rx_data      = sb_out_beat.data;
  assign tcp_rx_last      = sb_out_beat.last;
  assign tcp_rx_err       = sb_out_beat.err;
  assign frame_ok_count   = ok_cnt_q;
  assign frame_drop_count = drop_cnt_q;

endmodule
